// File: rtl/fast_intr_ctrl_pkg.sv
// Shared register map, register-bus types and helpers for the fast interrupt controller.
package fast_intr_ctrl_pkg;

    localparam int unsigned NUM_FAST_IRQ = 16;
    localparam int unsigned REG_AW       = 32;
    localparam int unsigned REG_DW       = 32;
    localparam int unsigned REG_SW       = REG_DW / 8;

    localparam logic [3:0] FAST_INTR_PENDING_OFFSET  = 4'h0;
    localparam logic [3:0] FAST_INTR_ENABLE_OFFSET   = 4'h4;
    localparam logic [3:0] FAST_INTR_MODE_OFFSET     = 4'h8;
    localparam logic [3:0] FAST_INTR_POLARITY_OFFSET = 4'hC;

    typedef logic [NUM_FAST_IRQ-1:0] fast_irq_vec_t;

    typedef struct packed {
        logic              valid;
        logic              write;
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] wdata;
        logic [REG_SW-1:0] wstrb;
    } reg_req_t;

    typedef struct packed {
        logic [REG_DW-1:0] rdata;
        logic              error;
        logic              ready;
    } reg_rsp_t;

    // Bits below num_irq are implemented; the rest read 0 and ignore writes.
    function automatic fast_irq_vec_t irq_mask(input int unsigned num_irq);
        fast_irq_vec_t m;
        for (int unsigned i = 0; i < NUM_FAST_IRQ; i++) begin
            m[i] = (i < num_irq);
        end
        return m;
    endfunction

    function automatic fast_irq_vec_t strb_mask(input logic [1:0] wstrb);
        return {{8{wstrb[1]}}, {8{wstrb[0]}}};
    endfunction

    function automatic fast_irq_vec_t merge_bits(input fast_irq_vec_t old_val,
                                                 input fast_irq_vec_t new_val,
                                                 input fast_irq_vec_t mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    function automatic int unsigned lowest_set_idx(input fast_irq_vec_t v);
        int unsigned idx = 0;
        for (int i = NUM_FAST_IRQ - 1; i >= 0; i--) begin
            if (v[i]) idx = unsigned'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/fast_intr_ctrl_reg_if.sv
// Register-bus front end: address decode, byte-lane merge, error response, read mux.
// Holds ENABLE/MODE/POLARITY; PENDING lives in the top and is cleared via o_pending_clr.
module fast_intr_ctrl_reg_if
    import fast_intr_ctrl_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  reg_req_t      i_req,
    output reg_rsp_t      o_rsp,
    input  fast_irq_vec_t i_pending,
    output fast_irq_vec_t o_pending_clr,
    output fast_irq_vec_t o_enable,
    output fast_irq_vec_t o_mode,
    output fast_irq_vec_t o_polarity
);

    localparam fast_irq_vec_t ImplMask = irq_mask(NUM_IRQ);

    logic          w_addr_err;
    logic          w_access;
    logic [3:0]    w_offset;
    fast_irq_vec_t w_wmask;
    fast_irq_vec_t w_wdata;
    fast_irq_vec_t w_rdata;
    logic          w_wr_pending;
    logic          w_wr_enable;
    logic          w_wr_mode;
    logic          w_wr_polarity;
    logic          w_unused;

    fast_irq_vec_t r_enable;
    fast_irq_vec_t r_mode;
    fast_irq_vec_t r_polarity;

    assign w_offset   = i_req.addr[3:0];
    // Only the four word offsets at the very bottom of the window decode.
    assign w_addr_err = (i_req.addr[REG_AW-1:4] != '0) || (i_req.addr[1:0] != 2'b00);
    assign w_access   = i_req.valid && !w_addr_err;
    assign w_wmask    = strb_mask(i_req.wstrb[1:0]) & ImplMask;
    assign w_wdata    = i_req.wdata[NUM_FAST_IRQ-1:0];
    assign w_unused   = ^{i_req.wdata[REG_DW-1:NUM_FAST_IRQ], i_req.wstrb[REG_SW-1:2]};

    always_comb begin
        w_wr_pending  = 1'b0;
        w_wr_enable   = 1'b0;
        w_wr_mode     = 1'b0;
        w_wr_polarity = 1'b0;
        if (w_access && i_req.write) begin
            case (w_offset)
                FAST_INTR_PENDING_OFFSET:  w_wr_pending  = 1'b1;
                FAST_INTR_ENABLE_OFFSET:   w_wr_enable   = 1'b1;
                FAST_INTR_MODE_OFFSET:     w_wr_mode     = 1'b1;
                FAST_INTR_POLARITY_OFFSET: w_wr_polarity = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_access && !i_req.write) begin
            case (w_offset)
                FAST_INTR_PENDING_OFFSET:  w_rdata = i_pending & ImplMask;
                FAST_INTR_ENABLE_OFFSET:   w_rdata = r_enable;
                FAST_INTR_MODE_OFFSET:     w_rdata = r_mode;
                FAST_INTR_POLARITY_OFFSET: w_rdata = r_polarity;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_enable   <= '0;
            r_mode     <= '0;
            r_polarity <= '0;
        end else begin
            if (w_wr_enable)   r_enable   <= merge_bits(r_enable, w_wdata, w_wmask);
            if (w_wr_mode)     r_mode     <= merge_bits(r_mode, w_wdata, w_wmask);
            if (w_wr_polarity) r_polarity <= merge_bits(r_polarity, w_wdata, w_wmask);
        end
    end

    assign o_pending_clr = w_wr_pending ? (w_wdata & w_wmask) : '0;
    assign o_enable      = r_enable;
    assign o_mode        = r_mode;
    assign o_polarity    = r_polarity;

    assign o_rsp.rdata = REG_DW'(w_rdata);
    assign o_rsp.error = i_req.valid && w_addr_err;
    assign o_rsp.ready = i_req.valid;

endmodule

// File: rtl/fast_intr_ctrl.sv
// Fast interrupt controller: per-channel polarity, level/edge detect, latched pending, priority ID.
// Define FAST_INTR_CTRL_SYNC_EN to pass intr_i through a 2-flop synchroniser.
module fast_intr_ctrl
    import fast_intr_ctrl_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 16,
    parameter int unsigned ID_W    = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_IRQ-1:0]      intr_i,
    input  reg_req_t                reg_req_i,
    output reg_rsp_t                reg_rsp_o,
    output logic [NUM_FAST_IRQ-1:0] irq_fast_o,
    output logic                    irq_valid_o,
    output logic [ID_W-1:0]         irq_id_o
);

    localparam fast_irq_vec_t ImplMask = irq_mask(NUM_IRQ);

    logic [NUM_IRQ-1:0] w_src;
    fast_irq_vec_t      w_raw;
    fast_irq_vec_t      w_s;
    fast_irq_vec_t      w_set;
    fast_irq_vec_t      w_pending_clr;
    fast_irq_vec_t      w_enable;
    fast_irq_vec_t      w_mode;
    fast_irq_vec_t      w_polarity;

    fast_irq_vec_t      r_s_q;
    fast_irq_vec_t      r_pending;
    fast_irq_vec_t      r_irq_fast;

`ifdef FAST_INTR_CTRL_SYNC_EN
    logic [NUM_IRQ-1:0] r_sync1;
    logic [NUM_IRQ-1:0] r_sync2;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= intr_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_src = r_sync2;
`else
    assign w_src = intr_i;
`endif

    always_comb begin
        w_raw              = '0;
        w_raw[NUM_IRQ-1:0] = w_src;
    end

    assign w_s   = (w_raw ^ w_polarity) & ImplMask;
    assign w_set = ((w_mode & w_s & ~r_s_q) | (~w_mode & w_s)) & ImplMask;

    fast_intr_ctrl_reg_if #(
        .NUM_IRQ (NUM_IRQ)
    ) u_reg_if (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .i_req         (reg_req_i),
        .o_rsp         (reg_rsp_o),
        .i_pending     (r_pending),
        .o_pending_clr (w_pending_clr),
        .o_enable      (w_enable),
        .o_mode        (w_mode),
        .o_polarity    (w_polarity)
    );

    // s_q tracks in every mode so switching a live channel to edge does not fire.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s_q      <= '0;
            r_pending  <= '0;
            r_irq_fast <= '0;
        end else begin
            r_s_q      <= w_s;
            r_pending  <= w_set | (r_pending & ~w_pending_clr);
            r_irq_fast <= r_pending & w_enable;
        end
    end

    assign irq_fast_o  = r_irq_fast;
    assign irq_valid_o = |r_irq_fast;
    assign irq_id_o    = ID_W'(lowest_set_idx(r_irq_fast));

endmodule

// File: tb/tb_fast_intr_ctrl.sv
// Self-checking bench for fast_intr_ctrl: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model.
module tb_fast_intr_ctrl;
    import fast_intr_ctrl_pkg::*;

`ifdef FAST_INTR_CTRL_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic [15:0] intr = '0;
    reg_req_t    req  = '0;
    reg_rsp_t    rsp;
    logic [15:0] fast;
    logic        valid;
    logic [3:0]  id;

    logic [4:0]  intr5 = '0;
    reg_req_t    req5  = '0;
    reg_rsp_t    rsp5;
    logic [15:0] fast5;
    logic        valid5;
    logic [2:0]  id5;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fast_intr_ctrl #(
        .NUM_IRQ (16),
        .ID_W    (4)
    ) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .intr_i      (intr),
        .reg_req_i   (req),
        .reg_rsp_o   (rsp),
        .irq_fast_o  (fast),
        .irq_valid_o (valid),
        .irq_id_o    (id)
    );

    fast_intr_ctrl #(
        .NUM_IRQ (5),
        .ID_W    (3)
    ) u_dut5 (
        .clk_i       (clk),
        .rst_i       (rst),
        .intr_i      (intr5),
        .reg_req_i   (req5),
        .reg_rsp_o   (rsp5),
        .irq_fast_o  (fast5),
        .irq_valid_o (valid5),
        .irq_id_o    (id5)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] m_pend, m_en, m_mode, m_pol, m_sprev, m_fast;
    logic [15:0] m_dl [0:2];
    logic [15:0] m_raw, m_s, m_set, m_clr, m_lane, m_wd;
    logic        m_wr;

    function automatic logic bad_addr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a > 32'hC);
    endfunction

    function automatic logic [3:0] lowest(input logic [15:0] v);
        for (int i = 0; i < 16; i++) begin
            if (v[i]) return 4'(i);
        end
        return 4'd0;
    endfunction

    function automatic logic [15:0] model_reg(input logic [3:0] off);
        case (off)
            4'h0:    return m_pend;
            4'h4:    return m_en;
            4'h8:    return m_mode;
            4'hC:    return m_pol;
            default: return 16'h0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend  = '0; m_en = '0; m_mode = '0; m_pol = '0; m_sprev = '0; m_fast = '0;
            m_dl[0] = '0; m_dl[1] = '0; m_dl[2] = '0;
        end else begin
            // Source value seen this edge is intr as it stood SYNC edges earlier.
            m_dl[2] = m_dl[1];
            m_dl[1] = m_dl[0];
            m_dl[0] = intr;
            m_raw   = m_dl[SYNC];
            m_s     = m_raw ^ m_pol;
            for (int i = 0; i < 16; i++) begin
                if (m_mode[i]) m_set[i] = m_s[i] && !m_sprev[i];
                else           m_set[i] = m_s[i];
            end
            m_lane = {{8{req.wstrb[1]}}, {8{req.wstrb[0]}}};
            m_wd   = req.wdata[15:0];
            m_wr   = req.valid && req.write && !bad_addr(req.addr);
            m_clr  = (m_wr && req.addr[3:0] == 4'h0) ? (m_wd & m_lane) : 16'h0;
            m_fast = m_pend & m_en;
            m_pend = m_set | (m_pend & ~m_clr);
            m_sprev = m_s;
            if (m_wr) begin
                case (req.addr[3:0])
                    4'h4: m_en   = (m_en   & ~m_lane) | (m_wd & m_lane);
                    4'h8: m_mode = (m_mode & ~m_lane) | (m_wd & m_lane);
                    4'hC: m_pol  = (m_pol  & ~m_lane) | (m_wd & m_lane);
                    default: ;
                endcase
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("model_irq_fast", 32'(fast), 32'(m_fast));
        check("model_irq_valid", 32'(valid), 32'(|m_fast));
        check("model_irq_id", 32'(id), 32'(lowest(m_fast)));
        check("model_ready", 32'(rsp.ready), 32'(req.valid));
        if (req.valid) check("model_error", 32'(rsp.error), 32'(bad_addr(req.addr)));
        if (req.valid && !req.write)
            check("model_rdata", rsp.rdata,
                  bad_addr(req.addr) ? 32'h0 : 32'(model_reg(req.addr[3:0])));
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req.valid = 1'b1; req.write = 1'b1; req.addr = a; req.wdata = d; req.wstrb = s;
        @(posedge clk); #1;
        req = '0;
    endtask

    task automatic bus_rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        req.valid = 1'b1; req.write = 1'b0; req.addr = a; req.wdata = '0; req.wstrb = '0;
        @(negedge clk);
        check(name, rsp.rdata, exp);
        @(posedge clk); #1;
        req = '0;
    endtask

    task automatic chk_out(input logic [15:0] ef, input logic [3:0] eid, input string name);
        check({name, "_fast"}, 32'(fast), 32'(ef));
        check({name, "_valid"}, 32'(valid), 32'(ef != 16'h0));
        check({name, "_id"}, 32'(id), 32'(eid));
    endtask

    task automatic bus5_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req5.valid = 1'b1; req5.write = 1'b1; req5.addr = a; req5.wdata = d; req5.wstrb = s;
        @(posedge clk); #1;
        req5 = '0;
    endtask

    task automatic bus5_rd(input logic [31:0] a, input logic [31:0] exp, input logic eerr,
                           input string name);
        req5.valid = 1'b1; req5.write = 1'b0; req5.addr = a; req5.wdata = '0; req5.wstrb = '0;
        @(negedge clk);
        check({name, "_rdata"}, rsp5.rdata, exp);
        check({name, "_error"}, 32'(rsp5.error), 32'(eerr));
        check({name, "_ready"}, 32'(rsp5.ready), 32'h1);
        @(posedge clk); #1;
        req5 = '0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        cycles(3);
        rst = 1'b0;
        chk_out(16'h0, 4'd0, "reset_out");
        bus_rd(32'h0, 32'h0, "reset_pending");

        // Edge channel 3, one-cycle pulse.
        bus_wr(32'h8, 32'h0008, 4'hF);
        bus_wr(32'h4, 32'h0008, 4'hF);
        intr = 16'h0008;
        cycles(1);
        intr = 16'h0;
        cycles(SYNC + 2);
        chk_out(16'h0008, 4'd3, "edge");
        bus_rd(32'h0, 32'h0008, "edge_pending");
        bus_wr(32'h0, 32'h0008, 4'hF);
        cycles(1);
        chk_out(16'h0, 4'd0, "edge_cleared");

        // Level channel 1 vs W1C.
        bus_wr(32'h8, 32'h0, 4'hF);
        intr = 16'h0002;
        cycles(SYNC + 2);
        bus_wr(32'h0, 32'h0002, 4'hF);
        bus_rd(32'h0, 32'h0002, "level_set_wins");
        intr = 16'h0;
        cycles(SYNC + 2);
        bus_wr(32'h0, 32'h0002, 4'hF);
        bus_rd(32'h0, 32'h0, "level_cleared");

        // Priority across bits 9, 4, 12.
        bus_wr(32'h4, 32'hFFFF, 4'hF);
        bus_wr(32'h8, 32'hFFFF, 4'hF);
        intr = 16'h1210;
        cycles(1);
        intr = 16'h0;
        cycles(SYNC + 2);
        chk_out(16'h1210, 4'd4, "prio");
        bus_wr(32'h0, 32'h0010, 4'hF);
        cycles(1);
        chk_out(16'h1200, 4'd9, "prio_after_clr");
        bus_wr(32'h0, 32'hFFFF, 4'hF);
        cycles(1);
        chk_out(16'h0, 4'd0, "prio_all_clr");

        // Falling edge on channel 0 with output disabled.
        bus_wr(32'h4, 32'h0, 4'hF);
        intr = 16'h0001;
        cycles(SYNC + 2);
        bus_wr(32'hC, 32'h0001, 4'hF);
        cycles(SYNC + 2);
        bus_wr(32'h0, 32'hFFFF, 4'hF);
        bus_rd(32'h0, 32'h0, "pol_precleared");
        intr = 16'h0;
        cycles(SYNC + 2);
        bus_rd(32'h0, 32'h0001, "pol_falling_pending");
        chk_out(16'h0, 4'd0, "pol_gated");
        bus_wr(32'h4, 32'h0001, 4'hF);
        chk_out(16'h0, 4'd0, "pol_enable_lag");
        cycles(1);
        chk_out(16'h0001, 4'd0, "pol_enabled");

        // Asynchronous reset with pending = 0x0005.
        bus_wr(32'h4, 32'hFFFF, 4'hF);
        bus_wr(32'hC, 32'h0, 4'hF);
        bus_wr(32'h0, 32'hFFFF, 4'hF);
        intr = 16'h0005;
        cycles(1);
        intr = 16'h0;
        cycles(SYNC + 2);
        bus_rd(32'h0, 32'h0005, "prereset_pending");
        chk_out(16'h0005, 4'd0, "prereset");
        rst = 1'b1;
        #1;
        chk_out(16'h0, 4'd0, "async_reset");
        cycles(2);
        rst = 1'b0;
        bus_rd(32'h0, 32'h0, "postreset_pending");
        bus_rd(32'h4, 32'h0, "postreset_enable");

        // Bus behaviour on the 5-channel instance.
        bus5_rd(32'h10, 32'h0, 1'b1, "err_oob");
        bus5_rd(32'h6, 32'h0, 1'b1, "err_misaligned");
        bus5_wr(32'h4, 32'hFFFF, 4'hF);
        bus5_rd(32'h4, 32'h001F, 1'b0, "enable_masked");
        bus5_wr(32'h8, 32'hFF00, 4'b0010);
        bus5_rd(32'h8, 32'h0, 1'b0, "mode_high_lane");
        bus5_wr(32'h8, 32'h00FF, 4'b0010);
        bus5_rd(32'h8, 32'h0, 1'b0, "mode_strobe_off");
        bus5_wr(32'h8, 32'h00FF, 4'b0001);
        bus5_rd(32'h8, 32'h001F, 1'b0, "mode_low_lane");
        bus5_wr(32'h18, 32'hFFFF, 4'hF);
        bus5_rd(32'hC, 32'h0, 1'b0, "err_write_ignored");

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            intr = intr ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                req.valid = 1'b1;
                req.write = 1'($urandom_range(0, 1));
                req.addr  = 32'($urandom_range(0, 3)) << 2;
                if ($urandom_range(0, 7) == 0) req.addr = $urandom & 32'h3F;
                req.wdata = $urandom;
                req.wstrb = 4'($urandom);
            end else begin
                req = '0;
            end
            @(posedge clk); #1;
            if ((c % 700) == 350) begin
                rst = 1'b1;
                #2;
                rst = 1'b0;
            end
        end
        req  = '0;
        intr = '0;
        cycles(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
